// File: rtl/cache_axi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_master_if
// Brief    : AXI4-Lite bus between the cache memory stage and its slave.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/cache_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_master
// Brief    : Converts cache refill/writeback requests into single-beat
//            AXI4-Lite transactions, one per line word.
// Revision : 1.0 - initial release
// ============================================================================
module cache_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    localparam int LINE_W = DATA_W * WORDS
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              rd_mem_req,
    input  wire logic              wr_mem_req,
    input  wire logic              wr_rd_mem_req,
    input  wire logic [ADDR_W-1:0] rd_addr,
    input  wire logic [ADDR_W-1:0] wb_addr,
    input  wire logic [LINE_W-1:0] wb_line,
    output logic                   ready_mem,
    output logic [LINE_W-1:0]      fill_line,
    output logic                   fill_valid,
    output logic                   busy,
    output logic                   err,
    cache_axi_master_if.master     axi
);
    localparam int c_bytes    = DATA_W / 8;
    localparam int c_off_w    = $clog2(c_bytes);
    localparam int c_cnt_w    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int c_line_off = $clog2(WORDS * c_bytes);
    localparam logic [ADDR_W-1:0] c_line_mask =
        ~((ADDR_W'(1) << c_line_off) - ADDR_W'(1));
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WORDS - 1);

    localparam logic [2:0] c_s_idle    = 3'd0;
    localparam logic [2:0] c_s_wr_req  = 3'd1;
    localparam logic [2:0] c_s_wr_resp = 3'd2;
    localparam logic [2:0] c_s_rd_req  = 3'd3;
    localparam logic [2:0] c_s_rd_resp = 3'd4;
    localparam logic [2:0] c_s_done    = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_wb_base;
    logic [ADDR_W-1:0]  r_rd_base;
    logic [ADDR_W-1:0]  w_beat_off;
    logic [LINE_W-1:0]  r_wb_line;
    logic [LINE_W-1:0]  r_fill_line;
    logic               r_do_rd;
    logic               r_aw_done;
    logic               r_w_done;
    logic               r_err;
    logic               w_accept;
    logic               w_last;
    logic               w_aw_all;
    logic               w_w_all;

    assign w_accept = rd_mem_req | wr_mem_req | wr_rd_mem_req;
    assign w_last   = (r_cnt == c_last);
    assign w_aw_all = r_aw_done | (axi.awvalid & axi.awready);
    assign w_w_all  = r_w_done  | (axi.wvalid  & axi.wready);

    // Bases are line-aligned, so OR-ing in the word index never carries out of the line.
    assign w_beat_off  = ADDR_W'(r_cnt) << c_off_w;
    assign axi.awaddr  = r_wb_base | w_beat_off;
    assign axi.araddr  = r_rd_base | w_beat_off;
    assign axi.wdata   = r_wb_line[r_cnt*DATA_W +: DATA_W];
    assign axi.wstrb   = '1;
    assign fill_line   = r_fill_line;
    assign err         = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle: begin
                if (wr_rd_mem_req || wr_mem_req) begin
                    w_next = c_s_wr_req;
                end else if (rd_mem_req) begin
                    w_next = c_s_rd_req;
                end
            end
            c_s_wr_req: begin
                if (w_aw_all && w_w_all) begin
                    w_next = c_s_wr_resp;
                end
            end
            c_s_wr_resp: begin
                if (axi.bvalid) begin
                    if (!w_last) begin
                        w_next = c_s_wr_req;
                    end else if (r_do_rd) begin
                        w_next = c_s_rd_req;
                    end else begin
                        w_next = c_s_done;
                    end
                end
            end
            c_s_rd_req: begin
                if (axi.arready) begin
                    w_next = c_s_rd_resp;
                end
            end
            c_s_rd_resp: begin
                if (axi.rvalid) begin
                    w_next = w_last ? c_s_done : c_s_rd_req;
                end
            end
            c_s_done: w_next = c_s_idle;
            default:  w_next = c_s_idle;
        endcase
    end

    always_comb begin
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        ready_mem   = 1'b0;
        fill_valid  = 1'b0;
        busy        = (r_state != c_s_idle);
        case (r_state)
            c_s_wr_req: begin
                axi.awvalid = ~r_aw_done;
                axi.wvalid  = ~r_w_done;
            end
            c_s_wr_resp: axi.bready  = 1'b1;
            c_s_rd_req:  axi.arvalid = 1'b1;
            c_s_rd_resp: axi.rready  = 1'b1;
            c_s_done: begin
                ready_mem  = 1'b1;
                fill_valid = r_do_rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_wb_base   <= '0;
            r_rd_base   <= '0;
            r_wb_line   <= '0;
            r_fill_line <= '0;
            r_do_rd     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (w_accept) begin
                        r_wb_base <= wb_addr & c_line_mask;
                        r_rd_base <= rd_addr & c_line_mask;
                        r_wb_line <= wb_line;
                        r_do_rd   <= wr_rd_mem_req | (~wr_mem_req & rd_mem_req);
                        r_cnt     <= '0;
                    end
                end
                c_s_wr_req: begin
                    // Flags collapse back to zero once both halves of the beat are accepted.
                    if (w_aw_all && w_w_all) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_aw_done <= w_aw_all;
                        r_w_done  <= w_w_all;
                    end
                end
                c_s_wr_resp: begin
                    if (axi.bvalid) begin
                        if (axi.bresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                c_s_rd_resp: begin
                    if (axi.rvalid) begin
                        r_fill_line[r_cnt*DATA_W +: DATA_W] <= axi.rdata;
                        if (axi.rresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/cache_axi_master.md
Name: cache_axi_master

Overview:
Memory-side stage directly downstream of the data-cache controller. Turns its refill, writeback and writeback-then-refill requests into sequences of single-beat AXI4-Lite transactions, one per line word. Assembles returned read words into a fill line and pulses ready_mem back to the controller when the whole request is complete.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, AXI data width and cache word width
WORDS, 4, words per cache line; LINE_W = DATA_W*WORDS; power of 2, at least 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
rd_mem_req  in  1  start line refill from rd_addr
wr_mem_req  in  1  start line writeback of wb_line to wb_addr
wr_rd_mem_req  in  1  writeback, then refill
rd_addr  in  ADDR_W  refill address; low log2(WORDS*DATA_W/8) bits ignored
wb_addr  in  ADDR_W  writeback address; low bits ignored
wb_line  in  LINE_W  victim line; word i at bits [i*DATA_W +: DATA_W]
ready_mem  out  1  one-cycle completion pulse
fill_line  out  LINE_W  refill data; valid when fill_valid is high, held until the next refill
fill_valid  out  1  one-cycle pulse with ready_mem when a refill was performed
busy  out  1  high in every state except IDLE
err  out  1  sticky; set on any non-OKAY bresp/rresp, cleared only by reset
awaddr  out  ADDR_W; awvalid  out  1; awready  in  1
wdata  out  DATA_W; wstrb  out  DATA_W/8 (all ones); wvalid  out  1; wready  in  1
bresp  in  2; bvalid  in  1; bready  out  1
araddr  out  ADDR_W; arvalid  out  1; arready  in  1
rdata  in  DATA_W; rresp  in  2; rvalid  in  1; rready  out  1

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE. Word counter cnt is log2(WORDS) bits wide, minimum 1.
- Reset (async, also mid-transaction): state IDLE; cnt=0; all AXI valid/ready outputs, ready_mem, fill_valid, busy and err at 0; fill_line=0; latched addresses and data cleared. The slave must be reset together with this block.
- IDLE: requests are sampled only here.
  - Priority: wr_rd_mem_req > wr_mem_req > rd_mem_req.
  - On acceptance: latch line-aligned addresses, latch wb_line, latch mode (rd/wr/wr_rd), set cnt=0.
  - Next state: WR_REQ for wr and wr_rd; RD_REQ for rd.
  - Requests asserted outside IDLE are ignored and never queued.
- WR_REQ:
  - awvalid=1, awaddr=wb_base + cnt*(DATA_W/8); wvalid=1, wdata=word cnt.
  - AW and W handshakes are independent. Each valid drops after its own handshake, tracked by aw_done/w_done flags.
  - When both are done (same or different cycles), go to WR_RESP and clear the flags.
  - Valids and payloads stay stable until their handshake.
- WR_RESP:
  - bready=1. On bvalid: set err if bresp!=0.
  - If cnt==WORDS-1: cnt=0, then RD_REQ for wr_rd mode, else DONE.
  - Otherwise cnt+1, back to WR_REQ.
- RD_REQ: arvalid=1, araddr=rd_base + cnt*(DATA_W/8). On arready go to RD_RESP.
- RD_RESP:
  - rready=1. On rvalid: fill_line word cnt <= rdata; set err if rresp!=0.
  - If cnt==WORDS-1 go to DONE, else cnt+1 and back to RD_REQ.
- DONE: ready_mem=1 for exactly one cycle; fill_valid=1 in that cycle if the mode included a read; next state IDLE.
- Error responses do not abort: all remaining words are still transferred.
- Address wrap: base+offset stays inside the aligned line; no carry beyond line bits. Each beat address = base with word-index field replaced by cnt.
- Latency, zero-wait slave (ready high, response the cycle after the address handshake), request in cycle 0:
  - each word takes 2 cycles;
  - rd/wr: ready_mem in cycle 2*WORDS+1;
  - wr_rd: ready_mem in cycle 4*WORDS+1.
- At most one outstanding AXI transaction at any time. Read and write channels are never active simultaneously.

Test Plan:
- Refill, WORDS=4, rd_addr=0x1004, zero-wait slave returning 0xA0..0xA3 -> araddr 0x1000,0x1004,0x1008,0x100C; fill_line=0x000000A3_000000A2_000000A1_000000A0; ready_mem and fill_valid high in cycle 9 only.
- Writeback, wb_addr=0x2000, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles; 4 B handshakes; ready_mem pulses once; fill_valid stays 0.
- wr_rd_mem_req with zero-wait slave -> 4 writes complete before the first arvalid; ready_mem in cycle 17; both address sequences correct.
- rd_mem_req and wr_mem_req in the same cycle -> write-only sequence; no AR traffic.
- Slave returns rresp=2'b10 on word 1 -> all 4 reads still done; err=1 and stays 1 through a following clean request.
- rst low during RD_RESP with cnt=2 -> same-cycle arvalid/rready=0, busy=0, fill_line=0. After release, a new rd_mem_req restarts at word 0.
